// File: rtl/ctrlpkt_resp_gen.sv
// Control-packet response generator: pairs buffered packets with command results, swaps
// MAC/IP addresses and emits the response; packets left unanswered for TIMEOUT cycles are flushed as failed.
`timescale 1ns/1ps

module ctrlpkt_resp_gen_fifo #(
    parameter int W          = 64,
    parameter int DEPTH      = 16,
    parameter int ALF_MARGIN = 4
) (
    input  logic         Clk,
    input  logic         Reset_N,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         accept,
    output logic         empty,
    output logic         alf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Acceptance looks only at start-of-cycle occupancy, so a full FIFO rejects even while popping.
    assign accept = push && (count_q != CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign alf    = int'(count_q) >= DEPTH - ALF_MARGIN;
    assign rdata  = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge Clk) begin
        if (accept) mem_q[wr_ptr_q] <= wdata;
    end

    // NOTE: flops are updated with non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module ctrlpkt_resp_gen #(
    parameter int DW         = 512,
    parameter int DEPTH      = 16,
    parameter int ALF_MARGIN = 4,
    parameter int SWAP_IP    = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic           Clk,
    input  logic           Reset_N,
    input  logic [DW+7:0]  In_pkt,
    input  logic           In_pkt_wr,
    input  logic [255:0]   In_md,
    output logic           In_alf,
    input  logic [63:0]    Result,
    input  logic           Result_wr,
    output logic           Result_alf,
    output logic [DW+7:0]  Out_pkt,
    output logic           Out_pkt_wr,
    output logic [111:0]   Out_md,
    output logic           Out_md_wr,
    input  logic           Out_alf,
    output logic [31:0]    pkt_out_cnt,
    output logic [31:0]    result_in_cnt,
    output logic [31:0]    pkt_drop_cnt,
    output logic [31:0]    result_drop_cnt,
    output logic [31:0]    timeout_cnt
);
    localparam int PKTW = DW + 8;
    localparam int MDW  = 110;
    localparam int WCW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MATCH = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [PKTW+MDW-1:0] pf_wdata, pf_rdata;
    logic                pf_accept, pf_empty, pkt_pop;
    logic [63:0]         rf_rdata;
    logic                rf_accept, rf_empty, res_pop;
    logic [PKTW-1:0]     pkt_head, resp;
    logic [MDW-1:0]      md_head;
    logic                out_wr;
    logic                unused_md;

    logic [1:0]      state_q, state_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [PKTW-1:0] out_pkt_q, out_pkt_d;
    logic [111:0]    out_md_q, out_md_d;
    logic [31:0]     pkt_out_cnt_q, pkt_out_cnt_d;
    logic [31:0]     result_in_cnt_q, result_in_cnt_d;
    logic [31:0]     pkt_drop_cnt_q, pkt_drop_cnt_d;
    logic [31:0]     result_drop_cnt_q, result_drop_cnt_d;
    logic [31:0]     timeout_cnt_q, timeout_cnt_d;

    // Only the metadata fields that reach Out_md are buffered.
    assign pf_wdata  = {In_pkt, In_md[79:64], In_md[255:192], In_md[29:0]};
    assign unused_md = ^{In_md[191:80], In_md[63:30]};
    assign pkt_head  = pf_rdata[PKTW+MDW-1:MDW];
    assign md_head   = pf_rdata[MDW-1:0];

    ctrlpkt_resp_gen_fifo #(.W(PKTW + MDW), .DEPTH(DEPTH), .ALF_MARGIN(ALF_MARGIN)) u_pkt_fifo (
        .Clk(Clk), .Reset_N(Reset_N), .push(In_pkt_wr), .wdata(pf_wdata), .pop(pkt_pop),
        .rdata(pf_rdata), .accept(pf_accept), .empty(pf_empty), .alf(In_alf)
    );

    ctrlpkt_resp_gen_fifo #(.W(64), .DEPTH(DEPTH), .ALF_MARGIN(ALF_MARGIN)) u_res_fifo (
        .Clk(Clk), .Reset_N(Reset_N), .push(Result_wr), .wdata(Result), .pop(res_pop),
        .rdata(rf_rdata), .accept(rf_accept), .empty(rf_empty), .alf(Result_alf)
    );

    // state_d is this cycle's action; state_q remembers it so the registered output is flagged valid.
    always_comb begin
        state_d = IDLE;
        if (!Out_alf && !pf_empty && !rf_empty) begin
            state_d = MATCH;
        end else if (!Out_alf && (TIMEOUT != 0) && !pf_empty && rf_empty && (wait_q == WAIT_MAX)) begin
            state_d = FLUSH;
        end
        pkt_pop = (state_d != IDLE);
        res_pop = (state_d == MATCH);

        wait_d = wait_q;
        if (pkt_pop || pf_empty)                 wait_d = '0;
        else if (rf_empty && wait_q != WAIT_MAX) wait_d = wait_q + WCW'(1);
    end

    always_comb begin
        resp = pkt_head;
        resp[DW-1 -: 48]  = pkt_head[DW-49 -: 48];
        resp[DW-49 -: 48] = pkt_head[DW-1 -: 48];
        if (SWAP_IP == 1) begin
            resp[DW-209 -: 32] = pkt_head[DW-241 -: 32];
            resp[DW-241 -: 32] = pkt_head[DW-209 -: 32];
        end
        // A flushed packet reports failure by clearing the command status bit.
        resp[63:0] = (state_d == MATCH) ? rf_rdata : {pkt_head[63:61], 1'b0, pkt_head[59:0]};
        out_pkt_d  = pkt_pop ? resp : '0;
        out_md_d   = pkt_pop ? {2'b10, md_head} : '0;
    end

    assign out_wr = (state_q != IDLE);

    always_comb begin
        pkt_out_cnt_d     = pkt_out_cnt_q + {31'd0, out_wr};
        result_in_cnt_d   = result_in_cnt_q + {31'd0, Result_wr};
        pkt_drop_cnt_d    = pkt_drop_cnt_q + {31'd0, In_pkt_wr && !pf_accept};
        result_drop_cnt_d = result_drop_cnt_q + {31'd0, Result_wr && !rf_accept};
        timeout_cnt_d     = timeout_cnt_q + {31'd0, state_d == FLUSH};
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q           <= IDLE;
            wait_q            <= '0;
            out_pkt_q         <= '0;
            out_md_q          <= '0;
            pkt_out_cnt_q     <= '0;
            result_in_cnt_q   <= '0;
            pkt_drop_cnt_q    <= '0;
            result_drop_cnt_q <= '0;
            timeout_cnt_q     <= '0;
        end else begin
            state_q           <= state_d;
            wait_q            <= wait_d;
            out_pkt_q         <= out_pkt_d;
            out_md_q          <= out_md_d;
            pkt_out_cnt_q     <= pkt_out_cnt_d;
            result_in_cnt_q   <= result_in_cnt_d;
            pkt_drop_cnt_q    <= pkt_drop_cnt_d;
            result_drop_cnt_q <= result_drop_cnt_d;
            timeout_cnt_q     <= timeout_cnt_d;
        end
    end

    assign Out_pkt         = out_pkt_q;
    assign Out_md          = out_md_q;
    assign Out_pkt_wr      = out_wr;
    assign Out_md_wr       = out_wr;
    assign pkt_out_cnt     = pkt_out_cnt_q;
    assign result_in_cnt   = result_in_cnt_q;
    assign pkt_drop_cnt    = pkt_drop_cnt_q;
    assign result_drop_cnt = result_drop_cnt_q;
    assign timeout_cnt     = timeout_cnt_q;
endmodule

// File: tb/tb_ctrlpkt_resp_gen.sv
// Directed bench for ctrlpkt_resp_gen: dut_a has the timeout disabled, dut_t flushes after 8 cycles.
`timescale 1ns/1ps

module tb_ctrlpkt_resp_gen;
    localparam int DW   = 512;
    localparam int PKTW = DW + 8;

    logic            Clk = 1'b0;
    logic            Reset_N;
    logic [PKTW-1:0] In_pkt;
    logic            In_pkt_wr;
    logic [255:0]    In_md;
    logic [63:0]     Result;
    logic            Result_wr;
    logic            Out_alf;

    logic            a_in_alf, a_result_alf, a_out_pkt_wr, a_out_md_wr;
    logic [PKTW-1:0] a_out_pkt;
    logic [111:0]    a_out_md;
    logic [31:0]     a_pkt_out_cnt, a_result_in_cnt, a_pkt_drop_cnt, a_result_drop_cnt, a_timeout_cnt;
    logic            t_in_alf, t_result_alf, t_out_pkt_wr, t_out_md_wr;
    logic [PKTW-1:0] t_out_pkt;
    logic [111:0]    t_out_md;
    logic [31:0]     t_pkt_out_cnt, t_result_in_cnt, t_pkt_drop_cnt, t_result_drop_cnt, t_timeout_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int idle_viol = 0;
    int wr_viol = 0;

    logic [PKTW-1:0] obs_a_pkt[$];
    logic [111:0]    obs_a_md[$];
    int              obs_a_cyc[$];
    logic [PKTW-1:0] obs_t_pkt[$];
    int              obs_t_cyc[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    ctrlpkt_resp_gen #(.DW(DW), .DEPTH(16), .ALF_MARGIN(4), .SWAP_IP(1), .TIMEOUT(0)) dut_a (
        .Clk(Clk), .Reset_N(Reset_N), .In_pkt(In_pkt), .In_pkt_wr(In_pkt_wr), .In_md(In_md),
        .In_alf(a_in_alf), .Result(Result), .Result_wr(Result_wr), .Result_alf(a_result_alf),
        .Out_pkt(a_out_pkt), .Out_pkt_wr(a_out_pkt_wr), .Out_md(a_out_md), .Out_md_wr(a_out_md_wr),
        .Out_alf(Out_alf), .pkt_out_cnt(a_pkt_out_cnt), .result_in_cnt(a_result_in_cnt),
        .pkt_drop_cnt(a_pkt_drop_cnt), .result_drop_cnt(a_result_drop_cnt), .timeout_cnt(a_timeout_cnt)
    );

    ctrlpkt_resp_gen #(.DW(DW), .DEPTH(16), .ALF_MARGIN(4), .SWAP_IP(1), .TIMEOUT(8)) dut_t (
        .Clk(Clk), .Reset_N(Reset_N), .In_pkt(In_pkt), .In_pkt_wr(In_pkt_wr), .In_md(In_md),
        .In_alf(t_in_alf), .Result(Result), .Result_wr(Result_wr), .Result_alf(t_result_alf),
        .Out_pkt(t_out_pkt), .Out_pkt_wr(t_out_pkt_wr), .Out_md(t_out_md), .Out_md_wr(t_out_md_wr),
        .Out_alf(Out_alf), .pkt_out_cnt(t_pkt_out_cnt), .result_in_cnt(t_result_in_cnt),
        .pkt_drop_cnt(t_pkt_drop_cnt), .result_drop_cnt(t_result_drop_cnt), .timeout_cnt(t_timeout_cnt)
    );

    always @(negedge Clk) begin
        if (a_out_pkt_wr === 1'b1) begin
            obs_a_pkt.push_back(a_out_pkt);
            obs_a_md.push_back(a_out_md);
            obs_a_cyc.push_back(cyc);
        end
        if (t_out_pkt_wr === 1'b1) begin
            obs_t_pkt.push_back(t_out_pkt);
            obs_t_cyc.push_back(cyc);
        end
        if (a_out_pkt_wr !== a_out_md_wr || t_out_pkt_wr !== t_out_md_wr) wr_viol++;
        if (a_out_pkt_wr === 1'b0 && (a_out_pkt !== '0 || a_out_md !== '0)) idle_viol++;
        if (t_out_pkt_wr === 1'b0 && (t_out_pkt !== '0 || t_out_md !== '0)) idle_viol++;
    end

    // Packet image from named fields: DMAC [511:464], SMAC [463:416], SIP [303:272], DIP [271:240].
    function automatic logic [PKTW-1:0] build(input logic [7:0] hdr, input logic [63:0] fill,
                                              input logic [47:0] dmac, input logic [47:0] smac,
                                              input logic [31:0] sip, input logic [31:0] dip,
                                              input logic [63:0] low);
        logic [PKTW-1:0] v;
        v = {hdr, {8{fill}}};
        v[511:464] = dmac;
        v[463:416] = smac;
        v[303:272] = sip;
        v[271:240] = dip;
        v[63:0]    = low;
        return v;
    endfunction

    function automatic logic [PKTW-1:0] pk(input int i);
        return build(8'h80 ^ 8'(i), {32'hC0DE_0000, 32'(i)}, {16'hA000, 32'(i)}, {16'hB000, 32'(i)},
                     {16'hC000, 16'(i)}, {16'hD000, 16'(i)}, {32'h7777_0000, 32'(i)});
    endfunction

    function automatic logic [PKTW-1:0] xp(input int i, input logic [63:0] low);
        return build(8'h80 ^ 8'(i), {32'hC0DE_0000, 32'(i)}, {16'hB000, 32'(i)}, {16'hA000, 32'(i)},
                     {16'hD000, 16'(i)}, {16'hC000, 16'(i)}, low);
    endfunction

    function automatic logic [255:0] md_of(input int i);
        logic [31:0] w;
        w = 32'h9E37_79B9 * 32'(i + 1);
        return {8{w}};
    endfunction

    function automatic logic [111:0] exp_md(input logic [255:0] m);
        return {2'b10, m[79:64], m[255:192], m[29:0]};
    endfunction

    function automatic logic [63:0] res_of(input int i);
        return {32'hB000_0001, 32'h5500_0000 | 32'(i)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic do_p, input logic [PKTW-1:0] p, input logic [255:0] m,
                        input logic do_r, input logic [63:0] r);
        In_pkt = p;
        In_md = m;
        In_pkt_wr = do_p;
        Result = r;
        Result_wr = do_r;
        tick();
        In_pkt_wr = 1'b0;
        Result_wr = 1'b0;
    endtask

    task automatic wait_a(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (obs_a_pkt.size() >= n) break;
            tick();
        end
    endtask

    task automatic do_reset();
        Reset_N = 1'b0;
        In_pkt_wr = 1'b0;
        Result_wr = 1'b0;
        Out_alf = 1'b0;
        In_pkt = '0;
        In_md = '0;
        Result = '0;
        repeat (2) tick();
        Reset_N = 1'b1;
        obs_a_pkt.delete();
        obs_a_md.delete();
        obs_a_cyc.delete();
        obs_t_pkt.delete();
        obs_t_cyc.delete();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_out_pkt_wr !== 1'b0 || a_out_md_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b%b exp=00", a_out_pkt_wr, a_out_md_wr); end
        total++; if (a_out_pkt !== '0) begin bad++; $display("FAIL reset_out_pkt got=%h exp=0", a_out_pkt); end
        total++; if (a_out_md !== '0) begin bad++; $display("FAIL reset_out_md got=%h exp=0", a_out_md); end
        total++; if ({a_pkt_out_cnt, a_result_in_cnt, a_pkt_drop_cnt, a_result_drop_cnt, a_timeout_cnt} !== '0) begin
            bad++; $display("FAIL reset_cnt_a got=%h exp=0", {a_pkt_out_cnt, a_result_in_cnt, a_pkt_drop_cnt, a_result_drop_cnt, a_timeout_cnt}); end
        total++; if ({a_in_alf, a_result_alf, t_in_alf, t_result_alf} !== 4'b0) begin
            bad++; $display("FAIL reset_alf got=%b exp=0000", {a_in_alf, a_result_alf, t_in_alf, t_result_alf}); end
        total++; if ({t_out_pkt_wr, t_out_md_wr, t_out_md, t_pkt_out_cnt, t_result_in_cnt, t_pkt_drop_cnt, t_result_drop_cnt, t_timeout_cnt} !== '0) begin
            bad++; $display("FAIL reset_t got=%h exp=0", {t_out_pkt_wr, t_out_md_wr, t_out_md, t_pkt_out_cnt, t_result_in_cnt, t_pkt_drop_cnt, t_result_drop_cnt, t_timeout_cnt}); end
    endtask

    task automatic test_single();
        logic [PKTW-1:0] p, e;
        logic [255:0] m;
        do_reset();
        p = build(8'h5C, 64'h0123_4567_89AB_CDEF, 48'hAAAA_0000_0001, 48'hBBBB_0000_0002,
                  32'hC0A8_0001, 32'hC0A8_0002, 64'h0);
        e = build(8'h5C, 64'h0123_4567_89AB_CDEF, 48'hBBBB_0000_0002, 48'hAAAA_0000_0001,
                  32'hC0A8_0002, 32'hC0A8_0001, 64'hB000_0001_0000_00AA);
        m = md_of(1);
        push(1'b1, p, m, 1'b0, 64'h0);
        push(1'b0, '0, '0, 1'b1, 64'hB000_0001_0000_00AA);
        wait_a(1, 10);
        repeat (4) tick();
        total++; if (obs_a_pkt.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", obs_a_pkt.size()); end
        if (obs_a_pkt.size() == 1) begin
            total++; if (obs_a_pkt[0] !== e) begin bad++; $display("FAIL single_pkt got=%h exp=%h", obs_a_pkt[0], e); end
            total++; if (obs_a_md[0] !== exp_md(m)) begin bad++; $display("FAIL single_md got=%h exp=%h", obs_a_md[0], exp_md(m)); end
        end
        total++; if (a_pkt_out_cnt !== 32'd1) begin bad++; $display("FAIL single_pkt_out_cnt got=%0d exp=1", a_pkt_out_cnt); end
        total++; if (a_result_in_cnt !== 32'd1) begin bad++; $display("FAIL single_result_in_cnt got=%0d exp=1", a_result_in_cnt); end
    endtask

    task automatic test_back_to_back();
        int w0;
        do_reset();
        w0 = 0;
        for (int i = 0; i < 16; i++) begin
            push(1'b1, pk(i), md_of(i), 1'b1, res_of(i));
            if (i == 0) w0 = cyc;
        end
        wait_a(16, 40);
        repeat (3) tick();
        total++; if (obs_a_pkt.size() != 16) begin bad++; $display("FAIL b2b_count got=%0d exp=16", obs_a_pkt.size()); end
        if (obs_a_pkt.size() == 16) begin
            total++; if (obs_a_cyc[0] != w0 + 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", obs_a_cyc[0], w0 + 1); end
            for (int i = 0; i < 16; i++) begin
                total++; if (obs_a_pkt[i] !== xp(i, res_of(i))) begin bad++; $display("FAIL b2b_pkt[%0d] got=%h exp=%h", i, obs_a_pkt[i], xp(i, res_of(i))); end
                total++; if (obs_a_md[i] !== exp_md(md_of(i))) begin bad++; $display("FAIL b2b_md[%0d] got=%h exp=%h", i, obs_a_md[i], exp_md(md_of(i))); end
                total++; if (obs_a_cyc[i] != obs_a_cyc[0] + i) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, obs_a_cyc[i], obs_a_cyc[0] + i); end
            end
        end
        total++; if (a_pkt_out_cnt !== 32'd16) begin bad++; $display("FAIL b2b_pkt_out_cnt got=%0d exp=16", a_pkt_out_cnt); end
        total++; if (a_pkt_drop_cnt !== 32'd0 || a_result_drop_cnt !== 32'd0) begin
            bad++; $display("FAIL b2b_drops got=%0d/%0d exp=0/0", a_pkt_drop_cnt, a_result_drop_cnt); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            push(1'b1, pk(k), md_of(k), 1'b0, 64'h0);
            total++; if (a_in_alf !== (k >= 12)) begin bad++; $display("FAIL fill_in_alf[%0d] got=%b exp=%b", k, a_in_alf, k >= 12); end
        end
        repeat (5) tick();
        total++; if (a_pkt_drop_cnt !== 32'd1) begin bad++; $display("FAIL fill_pkt_drop got=%0d exp=1", a_pkt_drop_cnt); end
        total++; if (obs_a_pkt.size() != 0) begin bad++; $display("FAIL fill_no_output got=%0d exp=0", obs_a_pkt.size()); end
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            push(1'b0, '0, '0, 1'b1, res_of(k));
            total++; if (a_result_alf !== (k >= 12)) begin bad++; $display("FAIL fill_result_alf[%0d] got=%b exp=%b", k, a_result_alf, k >= 12); end
        end
        tick();
        total++; if (a_result_drop_cnt !== 32'd1) begin bad++; $display("FAIL fill_result_drop got=%0d exp=1", a_result_drop_cnt); end
        total++; if (a_result_in_cnt !== 32'd17) begin bad++; $display("FAIL fill_result_in got=%0d exp=17", a_result_in_cnt); end
    endtask

    task automatic test_timeout();
        logic [PKTW-1:0] p, e;
        int w;
        do_reset();
        p = build(8'h3A, 64'h1357_9BDF_2468_ACE0, 48'h0A0B_0C0D_0E0F, 48'h1A1B_1C1D_1E1F,
                  32'h0A00_0001, 32'h0A00_0002, 64'hF000_0000_1234_5678);
        e = build(8'h3A, 64'h1357_9BDF_2468_ACE0, 48'h1A1B_1C1D_1E1F, 48'h0A0B_0C0D_0E0F,
                  32'h0A00_0002, 32'h0A00_0001, 64'hE000_0000_1234_5678);
        push(1'b1, p, md_of(7), 1'b0, 64'h0);
        w = cyc;
        for (int k = 0; k < 30; k++) begin
            if (obs_t_pkt.size() >= 1) break;
            tick();
        end
        repeat (12) tick();
        total++; if (obs_t_pkt.size() != 1) begin bad++; $display("FAIL timeout_count got=%0d exp=1", obs_t_pkt.size()); end
        if (obs_t_pkt.size() >= 1) begin
            total++; if (obs_t_cyc[0] != w + 9) begin bad++; $display("FAIL timeout_cycle got=%0d exp=%0d", obs_t_cyc[0], w + 9); end
            total++; if (obs_t_pkt[0] !== e) begin bad++; $display("FAIL timeout_pkt got=%h exp=%h", obs_t_pkt[0], e); end
        end
        total++; if (t_timeout_cnt !== 32'd1) begin bad++; $display("FAIL timeout_cnt got=%0d exp=1", t_timeout_cnt); end
        total++; if (obs_a_pkt.size() != 0 || a_timeout_cnt !== 32'd0) begin
            bad++; $display("FAIL timeout_disabled got=%0d/%0d exp=0/0", obs_a_pkt.size(), a_timeout_cnt); end
    endtask

    task automatic test_out_alf();
        do_reset();
        Out_alf = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, pk(20 + i), md_of(20 + i), 1'b1, res_of(20 + i));
        repeat (10) tick();
        total++; if (obs_a_pkt.size() != 0) begin bad++; $display("FAIL alf_blocked got=%0d exp=0", obs_a_pkt.size()); end
        Out_alf = 1'b0;
        tick();
        Out_alf = 1'b1;
        repeat (6) tick();
        total++; if (obs_a_pkt.size() != 1) begin bad++; $display("FAIL alf_inflight got=%0d exp=1", obs_a_pkt.size()); end
        Out_alf = 1'b0;
        wait_a(4, 20);
        repeat (3) tick();
        total++; if (obs_a_pkt.size() != 4) begin bad++; $display("FAIL alf_release got=%0d exp=4", obs_a_pkt.size()); end
        if (obs_a_pkt.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                total++; if (obs_a_pkt[i] !== xp(20 + i, res_of(20 + i))) begin
                    bad++; $display("FAIL alf_pkt[%0d] got=%h exp=%h", i, obs_a_pkt[i], xp(20 + i, res_of(20 + i))); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        Out_alf = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, pk(30 + i), md_of(30 + i), 1'b1, res_of(30 + i));
        repeat (3) tick();
        total++; if (a_result_in_cnt !== 32'd3) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=3", a_result_in_cnt); end
        Out_alf = 1'b0;
        tick();
        total++; if (a_out_pkt_wr !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", a_out_pkt_wr); end
        Reset_N = 1'b0;
        #1;
        total++; if (a_out_pkt_wr !== 1'b0 || a_out_pkt !== '0 || a_out_md !== '0) begin
            bad++; $display("FAIL mid_out_zero got=%b/%h exp=0/0", a_out_pkt_wr, a_out_pkt); end
        total++; if ({a_pkt_out_cnt, a_result_in_cnt, a_pkt_drop_cnt, a_result_drop_cnt, a_timeout_cnt} !== '0) begin
            bad++; $display("FAIL mid_cnt_zero got=%h exp=0", {a_pkt_out_cnt, a_result_in_cnt, a_pkt_drop_cnt, a_result_drop_cnt, a_timeout_cnt}); end
        repeat (2) tick();
        Reset_N = 1'b1;
        repeat (10) tick();
        total++; if (obs_a_pkt.size() != 0) begin bad++; $display("FAIL mid_no_output got=%0d exp=0", obs_a_pkt.size()); end
        push(1'b1, pk(40), md_of(40), 1'b1, res_of(40));
        wait_a(1, 10);
        repeat (3) tick();
        total++; if (obs_a_pkt.size() != 1) begin bad++; $display("FAIL mid_resume_count got=%0d exp=1", obs_a_pkt.size()); end
        if (obs_a_pkt.size() == 1) begin
            total++; if (obs_a_pkt[0] !== xp(40, res_of(40))) begin bad++; $display("FAIL mid_resume_pkt got=%h exp=%h", obs_a_pkt[0], xp(40, res_of(40))); end
        end
    endtask

    task automatic test_idle_zero();
        total++; if (idle_viol != 0) begin bad++; $display("FAIL idle_outputs_zero got=%0d exp=0", idle_viol); end
        total++; if (wr_viol != 0) begin bad++; $display("FAIL wr_strobes_equal got=%0d exp=0", wr_viol); end
    endtask

    initial begin
        Reset_N = 1'b0;
        In_pkt_wr = 1'b0;
        Result_wr = 1'b0;
        Out_alf = 1'b0;
        In_pkt = '0;
        In_md = '0;
        Result = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_timeout();
        test_out_alf();
        test_reset_mid();
        test_idle_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ctrlpkt_resp_gen.md
CTRLPKT_RESP_GEN -- requirements
Module: ctrlpkt_resp_gen

Interface
REQ-001 Parameters (name, default, meaning):
- DW, 512, packet data width in bits, DW >= 512 and a multiple of 64.
- DEPTH, 16, entries per internal FIFO, a power of 2 from 4 to 256.
- ALF_MARGIN, 4, free-entry threshold used for almost-full.
- SWAP_IP, 1, 1 = also swap the IPv4 source and destination addresses.
- TIMEOUT, 1024, cycles before an unmatched packet is flushed, 0 = disabled.

REQ-002 Ports (name, direction, width, meaning):
- Clk, in, 1, clock.
- Reset_N, in, 1, reset, asynchronous, active-low.
- In_pkt, in, DW+8, single-beat control packet; [DW+7:DW] is the header.
- In_pkt_wr, in, 1, write strobe for In_pkt and In_md.
- In_md, in, 256, packet metadata.
- In_alf, out, 1, packet FIFO almost full.
- Result, in, 64, command result word.
- Result_wr, in, 1, Result write strobe.
- Result_alf, out, 1, result FIFO almost full.
- Out_pkt, out, DW+8, response packet.
- Out_pkt_wr, out, 1, Out_pkt valid.
- Out_md, out, 112, response metadata.
- Out_md_wr, out, 1, Out_md valid.
- Out_alf, in, 1, downstream almost full.
- pkt_out_cnt, result_in_cnt, pkt_drop_cnt, result_drop_cnt, timeout_cnt: out, 32 each, debug counters.

Function
REQ-003 The packet FIFO SHALL store {In_pkt, In_md} in register storage (no vendor IP), DEPTH entries, first-word-fall-through.
REQ-004 The result FIFO SHALL store Result, DEPTH entries, first-word-fall-through.
REQ-005 A write SHALL be accepted only when the FIFO's occupancy is below DEPTH at the start of the cycle, even if a pop occurs in the same cycle.
REQ-006 A rejected In_pkt_wr SHALL increment pkt_drop_cnt; a rejected Result_wr SHALL increment result_drop_cnt.
REQ-007 In_alf and Result_alf SHALL be combinational: 1 when the respective occupancy >= DEPTH-ALF_MARGIN.
REQ-008 The FSM SHALL have states IDLE, MATCH and FLUSH and evaluate every cycle:
- MATCH when both FIFOs are non-empty and Out_alf = 0.
- FLUSH when TIMEOUT != 0, the packet FIFO is non-empty, the result FIFO is empty, the wait counter = TIMEOUT, and Out_alf = 0.
- IDLE otherwise.
REQ-009 MATCH SHALL pop one entry from each FIFO; FLUSH SHALL pop the packet FIFO only.
REQ-010 Output SHALL be registered one cycle after the pop; back-to-back pops every cycle SHALL be supported with no bubble.
REQ-011 Out_pkt SHALL be:
- header unchanged;
- bits [DW-1:DW-48] and [DW-49:DW-96] (DMAC/SMAC) swapped;
- if SWAP_IP = 1, bits [DW-209:DW-240] and [DW-241:DW-272] swapped;
- all other bits passed through, except [63:0].
REQ-012 Out_pkt[63:0] SHALL be:
- in MATCH, the popped Result;
- in FLUSH, the stored packet's [63:0] with bit 60 forced to 0 (command failed).
REQ-013 Out_md SHALL be {2'b10, md[79:64], md[255:192], md[29:0]}.
REQ-014 Out_pkt_wr and Out_md_wr SHALL be 1 in exactly the cycles following a MATCH or FLUSH pop, and 0 otherwise.
REQ-015 When Out_pkt_wr = 0, Out_pkt and Out_md SHALL hold 0.
REQ-016 Wait counter:
- increments each cycle the packet FIFO is non-empty and the result FIFO is empty;
- clears on any pop or when the packet FIFO is empty;
- saturates at TIMEOUT.
REQ-017 Counter increments:
- pkt_out_cnt on each Out_pkt_wr;
- result_in_cnt on each Result_wr, whether accepted or rejected;
- timeout_cnt on each FLUSH.
REQ-018 All counters SHALL wrap modulo 2^32.
REQ-019 Out_alf = 1 SHALL block new pops from the next evaluation; an output already registered SHALL still be emitted.
REQ-020 Simultaneous push and pop on a non-full FIFO SHALL leave its occupancy unchanged.

Reset
REQ-021 When Reset_N = 0:
- FIFOs are emptied and the state is IDLE;
- Out_pkt, Out_md, Out_pkt_wr, Out_md_wr, all counters and the wait counter are 0.
REQ-022 Reset asserted mid-operation SHALL discard all buffered entries and any pending output with no partial emission; operation resumes on the first Clk edge after deassertion.

Verification
REQ-023 Write one packet (DMAC=A, SMAC=B, SIP=C, DIP=D), then Result=64'hB000_0001_0000_00AA; expect one output with DMAC=B, SMAC=A, SIP=D, DIP=C, [63:0]=B000_0001_0000_00AA; pkt_out_cnt=1.
REQ-024 Write 16 packets and 16 results on consecutive cycles (DEPTH=16) with Out_alf=0; expect 16 outputs in order, contiguous, with no bubble after the first.
REQ-025 Write 17 packets with no results and TIMEOUT=0; expect In_alf=1 at occupancy 12, pkt_drop_cnt=1 and no output.
REQ-026 TIMEOUT=8: write one packet with bit 60 = 1 and no result; expect exactly one FLUSH output with bit 60 = 0 after the wait counter reaches 8; timeout_cnt=1.
REQ-027 Hold Out_alf=1 with 4 matched pairs buffered; expect no output; release Out_alf and expect 4 outputs.
REQ-028 Assert Reset_N=0 while 3 pairs are buffered; expect all outputs and counters 0, and no output after release until new input arrives.
